// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the serial ALU receive path
package alu_pkg;

    localparam int PAYLOAD_W_DEF = 8;
    localparam int START_BIT     = 0;
    localparam int TYPE_BIT      = 1;
    localparam int WORD_BITS     = PAYLOAD_W_DEF + 2;

    typedef enum logic [1:0] {IDLE, SHIFT, EVAL, DROP} rx_state_t;

    typedef enum logic [1:0] {ERR_FRAME, ERR_SEQ, ERR_OVERRUN, ERR_TIMEOUT} rx_err_t;

endpackage

// File: rtl/alu_serial_word_rx.sv
// alu_serial_word_rx: collects framed serial bits into one word and flags words cut short
module alu_serial_word_rx
    import alu_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_n,
    input  logic                 din,
    input  logic                 flush,
    output logic                 word_done,
    output logic                 word_type,
    output logic                 start_bit,
    output logic                 frame_err,
    output logic [PAYLOAD_W-1:0] payload
);

    localparam int WB = PAYLOAD_W + 2;
    localparam int CW = $clog2(WB);

    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [WB-1:0] sh_q, sh_d;
    logic          sample;

    assign start_bit = sh_q[START_BIT];
    assign word_type = sh_q[TYPE_BIT];

    // Payload travels MSB first, so bit 2 of the word is the payload MSB
    always_comb begin
        for (int i = 0; i < PAYLOAD_W; i++) payload[PAYLOAD_W-1-i] = sh_q[i+2];
    end

    // Bit counter restarts whenever the frame drops, the word ends or the packet logic flushes
    always_comb begin
        sample    = !enable_n && !flush;
        word_done = sample && bit_cnt_q == CW'(WB - 1);
        frame_err = enable_n && bit_cnt_q != '0;
        bit_cnt_d = (!sample || word_done) ? '0 : bit_cnt_q + CW'(1);
        sh_d      = sh_q;
        if (sample) sh_d[bit_cnt_q] = din;
    end

    // Shift register and bit position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            sh_q      <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
        end
    end

endmodule

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: groups received words into A/B/opcode packets for the ALU core and reports errors
module alu_serial_rx
    import alu_pkg::*;
#(
    parameter int PAYLOAD_W   = PAYLOAD_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_n,
    input  logic                 din,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [PAYLOAD_W-1:0] a_out,
    output logic [PAYLOAD_W-1:0] b_out,
    output logic [PAYLOAD_W-1:0] op_out,
    output logic                 err_valid,
    output logic [1:0]           err_code
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    rx_state_t            state_q, state_d;
    rx_err_t              err_code_q, err_code_d;
    logic [1:0]           word_cnt_q, word_cnt_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic [PAYLOAD_W-1:0] a_q, a_d, b_q, b_d;
    logic [PAYLOAD_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d, op_out_q, op_out_d;
    logic                 op_valid_q, op_valid_d, err_valid_q, err_valid_d;
    logic                 word_done, word_type, start_bit, frame_err;
    logic [PAYLOAD_W-1:0] payload;
    logic                 is_eval, dropping, start_err, data_ok, data_seq, cmd_seq, pkt_done;
    logic                 to_drop, flush, load, overrun, timeout, any_frame, any_seq;

    alu_serial_word_rx #(.PAYLOAD_W(PAYLOAD_W)) u_word (
        .clk       (clk),
        .reset     (reset),
        .enable_n  (enable_n),
        .din       (din),
        .flush     (flush),
        .word_done (word_done),
        .word_type (word_type),
        .start_bit (start_bit),
        .frame_err (frame_err),
        .payload   (payload)
    );

    // Classify the word just completed; built only from registered state so flush has no loop
    always_comb begin
        is_eval   = state_q == EVAL;
        dropping  = state_q == DROP;
        start_err = is_eval && start_bit;
        data_ok   = is_eval && !start_bit && !word_type && word_cnt_q != 2'd2;
        data_seq  = is_eval && !start_bit && !word_type && word_cnt_q == 2'd2;
        cmd_seq   = is_eval && !start_bit && word_type && word_cnt_q != 2'd2;
        pkt_done  = is_eval && !start_bit && word_type && word_cnt_q == 2'd2;
        to_drop   = start_err || data_seq;
        flush     = dropping || to_drop;
    end

    // Packet sequencing, output register handshake, timeout and error priority
    always_comb begin
        load        = pkt_done && (!op_valid_q || op_ready);
        overrun     = pkt_done && !load;
        timeout     = enable_n && word_cnt_q != 2'd0 && to_cnt_q == TW'(TIMEOUT_CYC - 1);
        any_frame   = start_err || frame_err;
        any_seq     = data_seq || cmd_seq;
        state_d     = dropping ? (enable_n ? IDLE : DROP) : to_drop ? DROP : word_done ? EVAL : enable_n ? IDLE : SHIFT;
        word_cnt_d  = (any_frame || any_seq || pkt_done || timeout || dropping) ? 2'd0 : data_ok ? word_cnt_q + 2'd1 : word_cnt_q;
        to_cnt_d    = (enable_n && word_cnt_q != 2'd0) ? to_cnt_q + TW'(to_cnt_q != TW'(TIMEOUT_CYC)) : '0;
        a_d         = (data_ok && word_cnt_q == 2'd0) ? payload : a_q;
        b_d         = (data_ok && word_cnt_q == 2'd1) ? payload : b_q;
        op_valid_d  = load || (op_valid_q && !op_ready);
        a_out_d     = load ? a_q : a_out_q;
        b_out_d     = load ? b_q : b_out_q;
        op_out_d    = load ? payload : op_out_q;
        err_valid_d = any_frame || any_seq || overrun || timeout;
        err_code_d  = any_frame ? ERR_FRAME : any_seq ? ERR_SEQ : overrun ? ERR_OVERRUN : timeout ? ERR_TIMEOUT : ERR_FRAME;
    end

    // Packet FSM state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            to_cnt_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_valid_q  <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            op_out_q    <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_FRAME;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            to_cnt_q    <= to_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_valid_q  <= op_valid_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            op_out_q    <= op_out_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign op_valid  = op_valid_q;
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign op_out    = op_out_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule
